regfile_dump_reader: RTL and testbench
======================================

// Module: regfile_dump_reader
// PURPOSE
//  Sequential reader for the 32-entry CPU register file: on a start pulse it walks
//  register addresses 0..NREGS-1 through one regfile read port and streams each
//  (addr, data) pair out over a valid/ready handshake. Sits beside the regfile and
//  feeds a debug/trace sink (UART TX, test bench monitor) while the core is halted.
// PARAMETERS
//  NREGS  32  number of registers dumped (addresses 0..NREGS-1)
//  AW     6   address width, matches regfile addr ports
//  DW     32  data width, matches regfile read data
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  reset      in   1   synchronous, active-high reset
//  start      in   1   begin a dump; sampled only in IDLE
//  busy       out  1   high in READ, SEND, DONE
//  done       out  1   one-cycle pulse after the last pair is accepted
//  rd_addr    out  AW  to regfile addr1/addr2 (combinational read port)
//  rd_data    in   DW  from regfile readData; valid in the same cycle as rd_addr
//  out_valid  out  1   out_addr/out_data hold a pair
//  out_ready  in   1   sink accepts the pair when out_valid & out_ready
//  out_addr   out  AW  register index of the current pair
//  out_data   out  DW  register contents of the current pair
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, rd_addr=0, out_addr=0, out_data=0, out_valid=0,
//   busy=0, done=0. Reset in any state aborts the dump immediately; no done pulse.
//  rd_addr is driven from register idx in every state; it is never X.
//  FSM:
//   IDLE: start=1 -> idx<=0, go READ. start=0 -> stay.
//   READ: one cycle; out_data<=rd_data, out_addr<=idx; go SEND.
//   SEND: out_valid=1. If out_ready=0, stay; out_addr/out_data stay stable.
//     If out_ready=1: when idx==NREGS-1 go DONE, else idx<=idx+1 and go READ.
//   DONE: done=1 for this single cycle; idx<=0; go IDLE.
//  Latency: start in cycle 0 -> first out_valid in cycle 2. Each register takes at
//   least 2 cycles (READ + SEND). With out_ready held high, the last pair is
//   accepted in cycle 2*NREGS, done is high in cycle 2*NREGS+1, and the block is
//   back in IDLE in cycle 2*NREGS+2.
//  out_valid never drops without a handshake. It is never asserted outside SEND.
//  start while busy is ignored, with no restart and no queueing. start in the DONE
//   cycle is also ignored. start in IDLE in the cycle right after DONE is accepted.
//  Address 0 is streamed like any other index. The regfile returns 0 for it, and
//   the block passes that value through unmodified.
//  idx compares against NREGS-1 at width AW. There is no wrap past NREGS-1.
//  The block never writes the regfile. The regfile write port may change a
//   register mid-dump; the value captured in READ is the one reported.
// TESTING
//  1 Preload reg i = 0xA5000000|i, pulse start, out_ready=1 -> 32 pairs in order
//    (1,0xA5000001)..(31,0xA500001F), pair 0 data=0, done in cycle 65.
//  2 Backpressure: hold out_ready=0 for 5 cycles on idx 7 -> out_valid stays high,
//    out_addr=7 and out_data stay stable, and idx 8 appears only after acceptance.
//  3 Random out_ready (50%) over a full dump -> exactly 32 accepted pairs, no
//    duplicates or gaps, one done pulse.
//  4 Assert start repeatedly during a dump -> sequence unaffected, single done.
//  5 Assert reset while in SEND at idx 12 -> next cycle IDLE, all outputs 0, no
//    done pulse; a new start then dumps from idx 0.
//  6 Start in the cycle after done -> a second full dump runs cleanly; with
//    NREGS=4 -> 4 pairs, done in cycle 9.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//   Walks register addresses 0..NREGS-1 through one combinational regfile read
//   port and streams each (addr, data) pair to a debug/trace sink over a
//   valid/ready handshake. It is meant for use while the core is halted.
//
// Ports
//   clk        clock, all state changes on posedge
//   reset      synchronous, active-high; aborts any dump immediately
//   start      begin a dump (only looked at in IDLE)
//   busy       high while a dump is in progress (READ, SEND, DONE)
//   done       one-cycle pulse after the last pair has been accepted
//   rd_addr    regfile read address (always the current index)
//   rd_data    regfile read data, valid in the same cycle as rd_addr
//   out_valid  out_addr/out_data hold a pair for the sink
//   out_ready  sink accepts the pair when out_valid & out_ready
//   out_addr   register index of the current pair
//   out_data   register contents of the current pair
module regfile_dump_reader #(
  parameter int NREGS = 32,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic [AW-1:0] out_addr_reg, out_addr_next;
  logic [DW-1:0] out_data_reg, out_data_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      out_addr_reg <= '0;
      out_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      out_addr_reg <= out_addr_next;
      out_data_reg <= out_data_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    out_addr_next = out_addr_reg;
    out_data_next = out_data_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          idx_next   = '0;
          state_next = READ;
        end
      end
      READ: begin
        // Snapshot the register now; later regfile writes do not affect the pair.
        out_data_next = rd_data;
        out_addr_next = idx_reg;
        state_next    = SEND;
      end
      SEND: begin
        // Pair is held stable until the sink takes it.
        if (out_ready) begin
          if (idx_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + AW'(1);
            state_next = READ;
          end
        end
      end
      DONE: begin
        idx_next   = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rd_addr   = idx_reg;
  assign out_addr  = out_addr_reg;
  assign out_data  = out_data_reg;
  assign out_valid = (state_reg == SEND);
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        reset;

  // 32-register instance
  logic        start, busy, done, out_valid, out_ready;
  logic [5:0]  rd_addr, out_addr;
  logic [31:0] rd_data, out_data;

  // 4-register instance
  logic        start_4, busy_4, done_4, out_valid_4, out_ready_4;
  logic [5:0]  rd_addr_4, out_addr_4;
  logic [31:0] rd_data_4, out_data_4;

  logic [31:0] regs [64];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign rd_data   = regs[rd_addr];
  assign rd_data_4 = regs[rd_addr_4];

  regfile_dump_reader #(.NREGS(32), .AW(6), .DW(32)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data)
  );

  regfile_dump_reader #(.NREGS(4), .AW(6), .DW(32)) dut4 (
    .clk(clk), .reset(reset), .start(start_4), .busy(busy_4), .done(done_4),
    .rd_addr(rd_addr_4), .rd_data(rd_data_4), .out_valid(out_valid_4),
    .out_ready(out_ready_4), .out_addr(out_addr_4), .out_data(out_data_4)
  );

  typedef struct {
    logic        start;
    logic        ready;
    logic        valid;
    logic        busy;
    logic        done;
    logic [5:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_data(input int i);
    return (i == 0) ? 32'h0 : (32'hA500_0000 | 32'(i));
  endfunction

  // mode 0: ready always high; 1: random ready; 2: random ready + start spam;
  // 3: hold ready low 5 cycles on idx 7 and overwrite reg 7 during the stall.
  task automatic run_dump(input int mode, input int exp_done_cycle);
    int          cyc, nacc, ndone, hold, done_cyc;
    logic        pv;
    logic [5:0]  pa;
    logic [31:0] pd;
    cyc = 0; nacc = 0; ndone = 0; hold = 0; done_cyc = -1; pv = 1'b0;
    pa = '0; pd = '0;
    while (cyc < 2000) begin
      if (ndone > 0) begin
        chk("idle_after_done_busy", 64'(busy), 64'd0);
        chk("idle_after_done_valid", 64'(out_valid), 64'd0);
        break;
      end
      start = (cyc == 0) ? 1'b1 : ((mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
      case (mode)
        0: out_ready = 1'b1;
        3: begin
          if (out_valid && out_addr == 6'd7 && hold < 5) begin
            out_ready = 1'b0;
            hold++;
            if (hold == 2) regs[7] = 32'hDEAD_BEEF;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (pv) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_addr", 64'(out_addr), 64'(pa));
        chk("stall_data", 64'(out_data), 64'(pd));
      end
      if (!busy) chk("valid_outside_busy", 64'(out_valid), 64'd0);
      if (out_valid) chk("rd_addr_tracks_idx", 64'(rd_addr), 64'(out_addr));
      if (out_valid && out_ready) begin
        chk("pair_addr", 64'(out_addr), 64'(nacc));
        chk("pair_data", 64'(out_data), 64'(exp_data(nacc)));
        $display("pair addr=%0d data=%h cycle=%0d", out_addr, out_data, cyc);
        nacc++;
      end
      if (done) begin
        chk("done_after_last", 64'(nacc), 64'd32);
        ndone++;
        done_cyc = cyc;
      end
      pv = out_valid && !out_ready;
      pa = out_addr;
      pd = out_data;
      step();
      cyc++;
    end
    start = 1'b0;
    regs[7] = exp_data(7);
    chk("pair_count", 64'(nacc), 64'd32);
    chk("done_count", 64'(ndone), 64'd1);
    if (exp_done_cycle >= 0) chk("done_cycle", 64'(done_cyc), 64'(exp_done_cycle));
    $display("dump mode=%0d pairs=%0d done_cycle=%0d", mode, nacc, done_cyc);
  endtask

  initial begin
    int wait_cyc;
    for (int i = 0; i < 64; i++) regs[i] = exp_data(i);

    reset = 1'b1; start = 1'b0; out_ready = 1'b0; start_4 = 1'b0; out_ready_4 = 1'b0;
    step();
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst4_busy", 64'(busy_4), 64'd0);
    reset = 1'b0;
    step();

    // NREGS=4: cycle-exact dump, restart right after done, stall and start spam.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd1, 32'hA500_0001};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd2, 32'hA500_0002};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd3, 32'hA500_0003};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd0, 32'h0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 32'h0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 32'h0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd1, 32'hA500_0001};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd2, 32'hA500_0002};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd3, 32'hA500_0003};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd0, 32'h0};
    tbl[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0};
    tbl[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0};
    for (int i = 0; i < 23; i++) begin
      start_4     = tbl[i].start;
      out_ready_4 = tbl[i].ready;
      chk($sformatf("n4_valid_c%0d", i), 64'(out_valid_4), 64'(tbl[i].valid));
      chk($sformatf("n4_busy_c%0d", i), 64'(busy_4), 64'(tbl[i].busy));
      chk($sformatf("n4_done_c%0d", i), 64'(done_4), 64'(tbl[i].done));
      if (tbl[i].valid) begin
        chk($sformatf("n4_addr_c%0d", i), 64'(out_addr_4), 64'(tbl[i].addr));
        chk($sformatf("n4_data_c%0d", i), 64'(out_data_4), 64'(tbl[i].data));
      end
      $display("n4 cycle=%0d valid=%0b busy=%0b done=%0b addr=%0d data=%h",
               i, out_valid_4, busy_4, done_4, out_addr_4, out_data_4);
      step();
    end
    start_4 = 1'b0;

    // NREGS=32 full dumps.
    run_dump(0, 65);
    run_dump(3, 70);
    run_dump(1, -1);
    run_dump(2, -1);

    // Reset while in SEND at idx 12.
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    wait_cyc = 0;
    while (!(out_valid && out_addr == 6'd12) && wait_cyc < 200) begin
      step();
      wait_cyc++;
    end
    chk("reach_idx12", 64'(out_valid && out_addr == 6'd12), 64'd1);
    out_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_out_addr", 64'(out_addr), 64'd0);
    chk("abort_out_data", 64'(out_data), 64'd0);
    chk("abort_rd_addr", 64'(rd_addr), 64'd0);
    step();
    chk("abort_no_done", 64'(done), 64'd0);
    chk("abort_stay_idle", 64'(busy), 64'd0);
    $display("reset abort at idx 12 complete");
    run_dump(0, 65);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
